// File: rtl/prefetch_queue.sv
// Purpose : instruction prefetch queue; fetches 16-bit words as two byte reads and buffers DEPTH of them with their PCs.
// Latency : an instruction is visible at the head the cycle after its second byte returns (3 cycles from reset with zero-wait memory).
// Backpress: fetch stalls in WAIT while the queue is full; a redirect mid-request drains the outstanding byte before refetching.
module prefetch_queue #(
   parameter int M_WIDTH    = 8,
   parameter int INST_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      mem_req,
   output logic [M_WIDTH-1:0]        addr,
   input  logic                      mem_ready,
   input  logic [M_WIDTH-1:0]        data_in,
   input  logic                      flush,
   input  logic [M_WIDTH-1:0]        flush_pc,
   input  logic                      inst_take,
   output logic                      inst_valid,
   output logic [INST_WIDTH-1:0]     inst_out,
   output logic [M_WIDTH-1:0]        inst_pc,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [2:0] {IDLE, HI, LO, WAIT, DRAIN} state_t;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [M_WIDTH-1:0]    pc;
   } entry_t;

   state_t               state_q, state_d;
   logic [M_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [M_WIDTH-1:0]   hi_byte_q, hi_byte_d;
   logic [M_WIDTH-1:0]   drain_addr_q, drain_addr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   entry_t               entry_q [DEPTH];
   entry_t               entry_d [DEPTH];
   logic                 push;
   logic                 pop;

   // Head of the queue is presented straight from storage.
   assign inst_valid = (count_q != '0);
   assign inst_out   = entry_q[rd_ptr_q].inst;
   assign inst_pc    = entry_q[rd_ptr_q].pc;
   assign count      = count_q;

   // Request/address outputs; DRAIN replays the address that was outstanding when the redirect hit.
   always_comb begin
      mem_req = 1'b0;
      addr    = fetch_pc_q;
      case (state_q)
         HI:      begin mem_req = 1'b1; addr = fetch_pc_q; end
         LO:      begin mem_req = 1'b1; addr = fetch_pc_q + M_WIDTH'(1); end
         DRAIN:   begin mem_req = 1'b1; addr = drain_addr_q; end
         default: begin mem_req = 1'b0; addr = fetch_pc_q; end
      endcase
   end

   // Queue bookkeeping: flush beats both push and pop; push and pop together leave count unchanged.
   always_comb begin
      push     = (state_q == LO) && mem_ready && !flush;
      pop      = inst_take && inst_valid && !flush;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      entry_d  = entry_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) begin
            entry_d[wr_ptr_q] = '{inst: {hi_byte_q, data_in}, pc: fetch_pc_q};
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Fetch sequencer next state: two byte reads per instruction, stall on full, drain on redirect.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      hi_byte_d    = hi_byte_q;
      drain_addr_d = drain_addr_q;
      if (flush) begin
         fetch_pc_d = flush_pc;
         case (state_q)
            HI, LO: begin
               if (mem_ready) begin
                  state_d = HI;
               end else begin
                  state_d      = DRAIN;
                  drain_addr_d = addr;
               end
            end
            DRAIN:   state_d = mem_ready ? HI : DRAIN;
            default: state_d = HI;
         endcase
      end else begin
         case (state_q)
            IDLE: state_d = HI;
            HI: begin
               if (mem_ready) begin
                  hi_byte_d = data_in;
                  state_d   = LO;
               end
            end
            LO: begin
               if (mem_ready) begin
                  fetch_pc_d = fetch_pc_q + M_WIDTH'(2);
                  state_d    = (count_d < FULL) ? HI : WAIT;
               end
            end
            WAIT:    state_d = (count_d < FULL) ? HI : WAIT;
            DRAIN:   state_d = mem_ready ? HI : DRAIN;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and storage registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         fetch_pc_q   <= '0;
         hi_byte_q    <= '0;
         drain_addr_q <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         hi_byte_q    <= hi_byte_d;
         drain_addr_q <= drain_addr_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         entry_q      <= entry_d;
      end
   end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a byte memory model and selectable zero-wait/manual ready.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpress: exercises full-queue stall, same-cycle push/pop and drain after redirect.
module tb_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req;
   logic [7:0]  addr;
   logic        mem_ready;
   logic [7:0]  data_in;
   logic        flush = 1'b0;
   logic [7:0]  flush_pc = 8'h00;
   logic        inst_take = 1'b0;
   logic        inst_valid;
   logic [15:0] inst_out;
   logic [7:0]  inst_pc;
   logic [2:0]  count;

   logic        zw = 1'b1;
   logic        man_ready = 1'b0;
   logic [7:0]  tb_mem [256];
   int          n_cmp = 0;
   int          n_err = 0;

   assign mem_ready = zw ? mem_req : man_ready;
   assign data_in   = tb_mem[addr];

   prefetch_queue #(.M_WIDTH(8), .INST_WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .addr(addr), .mem_ready(mem_ready),
      .data_in(data_in), .flush(flush), .flush_pc(flush_pc), .inst_take(inst_take),
      .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      n_cmp++; if (addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
      n_cmp++; if (inst_out !== 16'h0000) begin n_err++; $display("FAIL reset_inst got %h want 0000", inst_out); end
      n_cmp++; if (inst_pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h want 00", inst_pc); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
   endtask

   task automatic test_zero_wait();
      rst = 1'b1;
      tick(); tick();
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL zw_early_valid got %b want 0", inst_valid); end
      tick();
      n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid got %b want 1", inst_valid); end
      n_cmp++; if (inst_out !== 16'h1234) begin n_err++; $display("FAIL zw_inst got %h want 1234", inst_out); end
      n_cmp++; if (inst_pc !== 8'h00) begin n_err++; $display("FAIL zw_pc got %h want 00", inst_pc); end
   endtask

   task automatic test_fill_wait();
      for (int i = 0; i < 6; i++) tick();
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", count); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_mem_req got %b want 0", mem_req); end
      n_cmp++; if (inst_out !== 16'h1234) begin n_err++; $display("FAIL full_head got %h want 1234", inst_out); end
      tick();
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL wait_hold got %b want 0", mem_req); end
      inst_take = 1'b1;
      tick();
      inst_take = 1'b0;
      n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL resume_mem_req got %b want 1", mem_req); end
      n_cmp++; if (addr !== 8'h08) begin n_err++; $display("FAIL resume_addr got %h want 08", addr); end
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pop_count got %0d want 3", count); end
      n_cmp++; if (inst_out !== 16'h5678) begin n_err++; $display("FAIL second_inst got %h want 5678", inst_out); end
      n_cmp++; if (inst_pc !== 8'h02) begin n_err++; $display("FAIL second_pc got %h want 02", inst_pc); end
      tick(); tick();
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL refill_count got %0d want 4", count); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      flush = 1'b1; flush_pc = 8'h10;
      tick();
      flush = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL wait_flush_count got %0d want 0", count); end
      n_cmp++; if (addr !== 8'h10) begin n_err++; $display("FAIL wait_flush_addr got %h want 10", addr); end
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL pre_b2b_count got %0d want 2", count); end
      inst_take = 1'b1;
      tick();
      inst_take = 1'b0;
      exp = {tb_mem[8'h12], tb_mem[8'h13]};
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d want 2", count); end
      n_cmp++; if (inst_pc !== 8'h12) begin n_err++; $display("FAIL b2b_pc got %h want 12", inst_pc); end
      n_cmp++; if (inst_out !== exp) begin n_err++; $display("FAIL b2b_inst got %h want %h", inst_out, exp); end
      inst_take = 1'b1;
      tick();
      exp = {tb_mem[8'h14], tb_mem[8'h15]};
      n_cmp++; if (inst_pc !== 8'h14) begin n_err++; $display("FAIL order_pc got %h want 14", inst_pc); end
      n_cmp++; if (inst_out !== exp) begin n_err++; $display("FAIL order_inst got %h want %h", inst_out, exp); end
      flush = 1'b1; flush_pc = 8'h20;
      tick();
      flush = 1'b0; inst_take = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_take_count got %0d want 0", count); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL flush_take_valid got %b want 0", inst_valid); end
      n_cmp++; if (addr !== 8'h20) begin n_err++; $display("FAIL flush_take_addr got %h want 20", addr); end
   endtask

   task automatic test_flush_drain();
      logic [15:0] exp;
      zw = 1'b0; man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      n_cmp++; if (addr !== 8'h21) begin n_err++; $display("FAIL lo_addr got %h want 21", addr); end
      flush = 1'b1; flush_pc = 8'h40;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (addr !== 8'h21) begin n_err++; $display("FAIL drain_addr got %h want 21", addr); end
         n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL drain_req got %b want 1", mem_req); end
         n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", inst_valid); end
         tick();
      end
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      n_cmp++; if (addr !== 8'h40) begin n_err++; $display("FAIL post_drain_addr got %h want 40", addr); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL post_drain_count got %0d want 0", count); end
      zw = 1'b1;
      tick(); tick();
      exp = {tb_mem[8'h40], tb_mem[8'h41]};
      n_cmp++; if (inst_pc !== 8'h40) begin n_err++; $display("FAIL redirect_pc got %h want 40", inst_pc); end
      n_cmp++; if (inst_out !== exp) begin n_err++; $display("FAIL redirect_inst got %h want %h", inst_out, exp); end
   endtask

   task automatic test_wrap();
      flush = 1'b1; flush_pc = 8'hFE;
      tick();
      flush = 1'b0;
      n_cmp++; if (addr !== 8'hFE) begin n_err++; $display("FAIL wrap_hi_addr got %h want fe", addr); end
      tick();
      n_cmp++; if (addr !== 8'hFF) begin n_err++; $display("FAIL wrap_lo_addr got %h want ff", addr); end
      tick();
      n_cmp++; if (inst_out !== 16'hABCD) begin n_err++; $display("FAIL wrap_inst got %h want abcd", inst_out); end
      n_cmp++; if (inst_pc !== 8'hFE) begin n_err++; $display("FAIL wrap_pc got %h want fe", inst_pc); end
      n_cmp++; if (addr !== 8'h00) begin n_err++; $display("FAIL wrap_next_addr got %h want 00", addr); end
   endtask

   task automatic test_async_reset();
      zw = 1'b0; man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      n_cmp++; if (addr !== 8'h01) begin n_err++; $display("FAIL pre_rst_addr got %h want 01", addr); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL arst_req got %b want 0", mem_req); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", inst_valid); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
      tick();
      rst = 1'b1; zw = 1'b1;
      tick();
      n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL restart_req got %b want 1", mem_req); end
      n_cmp++; if (addr !== 8'h00) begin n_err++; $display("FAIL restart_addr got %h want 00", addr); end
      tick(); tick();
      n_cmp++; if (inst_out !== 16'h1234) begin n_err++; $display("FAIL restart_inst got %h want 1234", inst_out); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'((i * 7) + 3);
      tb_mem[0] = 8'h12; tb_mem[1] = 8'h34; tb_mem[2] = 8'h56; tb_mem[3] = 8'h78;
      tb_mem[254] = 8'hAB; tb_mem[255] = 8'hCD;
      #3;
      test_reset();
      test_zero_wait();
      test_fill_wait();
      test_back_to_back();
      test_flush_drain();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
